// File: rtl/alu_pkg.sv
// Shared widths, opcodes and instruction layout for the issue/writeback stage and its ALU.
package alu_pkg;
    localparam int DATA_W     = 4;
    localparam int NREG       = 4;
    localparam int REG_AW     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SEL_W      = 3;
    localparam int INSTR_W    = SEL_W + 3 * REG_AW;

    localparam logic [SEL_W-1:0] SEL_SUB = 3'd0;
    localparam logic [SEL_W-1:0] SEL_ADD = 3'd1;
    localparam logic [SEL_W-1:0] SEL_OR  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_AND = 3'd3;
    localparam logic [SEL_W-1:0] SEL_SRA = 3'd4;
    localparam logic [SEL_W-1:0] SEL_ROL = 3'd5;
    localparam logic [SEL_W-1:0] SEL_LT  = 3'd6;
    localparam logic [SEL_W-1:0] SEL_EQ  = 3'd7;

    localparam int SEL_LSB = 6;
    localparam int RD_LSB  = 4;
    localparam int RS_LSB  = 2;
    localparam int RT_LSB  = 0;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.sel = raw[SEL_LSB +: SEL_W];
        d.rd  = raw[RD_LSB  +: REG_AW];
        d.rs  = raw[RS_LSB  +: REG_AW];
        d.rt  = raw[RT_LSB  +: REG_AW];
        return d;
    endfunction
endpackage

// File: rtl/issue_writeback_if.sv
// Instruction intake, ALU operand/result, writeback and debug-peek signals of issue_writeback.
interface issue_writeback_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    in_instr;
    logic                  hold;
    logic [DATA_W-1:0]     ex_rs;
    logic [DATA_W-1:0]     ex_rt;
    logic [SEL_W-1:0]      ex_sel;
    logic [DATA_W-1:0]     ex_rd;
    logic                  wb_valid;
    logic [REG_AW-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_AW-1:0]     dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    modport slave (
        input  in_valid, in_instr, hold, ex_rd, dbg_addr,
        output in_ready, ex_rs, ex_rt, ex_sel, wb_valid, wb_addr, wb_data, dbg_data
    );

    modport master (
        output in_valid, in_instr, hold, ex_rd, dbg_addr,
        input  in_ready, ex_rs, ex_rt, ex_sel, wb_valid, wb_addr, wb_data, dbg_data
    );
endinterface

// File: rtl/issue_writeback_instr_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_dout whenever not empty.
module instr_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_push && r_wr_ptr == AW'(gi)) begin
                    r_mem[gi] <= i_din;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/issue_writeback.sv
// Issue + writeback stage around a combinational ALU; define BYPASS_EN to forward ex_rd
// into dependent operands instead of inserting a one-cycle bubble.
module issue_writeback
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    issue_writeback_if.slave bus
);
    logic [INSTR_W-1:0] w_head_raw;
    instr_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_haz_rs;
    logic               w_haz_rt;
    logic               w_stall;
    logic [DATA_W-1:0]  w_opa;
    logic [DATA_W-1:0]  w_opb;

    logic [DATA_W-1:0]  r_regfile [NREG];
    logic               r_iss_valid;
    logic [REG_AW-1:0]  r_iss_rd;
    logic [DATA_W-1:0]  r_ex_rs;
    logic [DATA_W-1:0]  r_ex_rt;
    logic [SEL_W-1:0]   r_ex_sel;
    logic               r_wb_valid;
    logic [REG_AW-1:0]  r_wb_addr;
    logic [DATA_W-1:0]  r_wb_data;

    instr_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (bus.in_instr),
        .i_pop   (w_pop),
        .o_dout  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head      = decode(w_head_raw);
    assign bus.in_ready = !w_full;
    assign w_push      = bus.in_valid && !w_full;

    // Hazard: the head reads the register the in-flight instruction writes this edge.
    assign w_haz_rs = r_iss_valid && (w_head.rs == r_iss_rd);
    assign w_haz_rt = r_iss_valid && (w_head.rt == r_iss_rd);

`ifdef BYPASS_EN
    assign w_stall = 1'b0;
    assign w_opa   = w_haz_rs ? bus.ex_rd : r_regfile[w_head.rs];
    assign w_opb   = w_haz_rt ? bus.ex_rd : r_regfile[w_head.rt];
`else
    assign w_stall = w_haz_rs || w_haz_rt;
    assign w_opa   = r_regfile[w_head.rs];
    assign w_opb   = r_regfile[w_head.rt];
`endif

    assign w_pop = !w_empty && !bus.hold && !w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_regfile[gi] <= '0;
                end else if (r_iss_valid && r_iss_rd == REG_AW'(gi)) begin
                    r_regfile[gi] <= bus.ex_rd;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_rd    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_sel    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
        end else begin
            r_iss_valid <= w_pop;
            if (w_pop) begin
                r_ex_rs  <= w_opa;
                r_ex_rt  <= w_opb;
                r_ex_sel <= w_head.sel;
                r_iss_rd <= w_head.rd;
            end
            r_wb_valid <= r_iss_valid;
            if (r_iss_valid) begin
                r_wb_addr <= r_iss_rd;
                r_wb_data <= bus.ex_rd;
            end
        end
    end

    assign bus.ex_rs    = r_ex_rs;
    assign bus.ex_rt    = r_ex_rt;
    assign bus.ex_sel   = r_ex_sel;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_addr  = r_wb_addr;
    assign bus.wb_data  = r_wb_data;
    assign bus.dbg_data = r_regfile[bus.dbg_addr];
endmodule
